// File: rtl/seq_divider_dw_pkg.sv
// Shared arithmetic types for the sequential divider.
//   state_t   : divider control state (IDLE, BUSY, DONE), 2-bit encoding
//   cnt_width : width of a step counter that must hold the value dw
package seq_divider_dw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/seq_divider_dw_div_step.sv
// One restoring-division step (purely combinational).
//   rem_i  : partial remainder, DW+1 bits
//   msb_i  : dividend bit shifted into the remainder this step
//   div_i  : divisor
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced by this step
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW:0]   rem_i,
  input  logic          msb_i,
  input  logic [DW-1:0] div_i,
  output logic [DW:0]   rem_o,
  output logic          qbit_o
);

  logic [DW:0] shifted;
  logic [DW:0] trial;

  always_comb begin
    shifted = {rem_i[DW-1:0], msb_i};
    trial   = shifted - {1'b0, div_i};
    // The comparison looks at the full shifted value including rem_i[DW].
    // That bit is always zero after a restoring step, so this matches the
    // borrow of the (DW+1)-bit trial subtraction.
    qbit_o  = ({rem_i, msb_i} >= {2'b00, div_i});
    rem_o   = qbit_o ? trial : shifted;
  end

endmodule

// File: rtl/seq_divider_dw.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, resetn          : clock, asynchronous active-low reset
//   iValid/oReady        : operand handshake (oReady high only in IDLE)
//   iDividend, iDivisor  : unsigned operands, DW bits
//   oValid/iReady        : result handshake (oValid high only in DONE)
//   oQuotient/oRemainder : result, held until consumed
//   oDivZero             : result came from a zero divisor
module seq_divider_dw
  import seq_divider_dw_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          iValid,
  output logic          oReady,
  input  logic [DW-1:0] iDividend,
  input  logic [DW-1:0] iDivisor,
  output logic          oValid,
  input  logic          iReady,
  output logic [DW-1:0] oQuotient,
  output logic [DW-1:0] oRemainder,
  output logic          oDivZero
);

  localparam int CW = cnt_width(DW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW:0]   rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [DW:0]   step_rem;
  logic          step_qbit;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the remainder while the new quotient bit enters at the LSB.
  div_step #(.DW(DW)) u_step (
    .rem_i  (rem_q),
    .msb_i  (quo_q[DW-1]),
    .div_i  (div_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          if (iDivisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = {1'b0, iDividend};
            dz_d    = 1'b1;
          end else begin
            state_d = BUSY;
            div_d   = iDivisor;
            quo_d   = iDividend;
            rem_d   = '0;
            cnt_d   = CW'(DW);
            dz_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = {quo_q[DW-2:0], step_qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign oReady     = (state_q == IDLE);
  assign oValid     = (state_q == DONE);
  assign oQuotient  = quo_q;
  assign oRemainder = rem_q[DW-1:0];
  assign oDivZero   = dz_q;

endmodule

// File: tb/tb_seq_divider_dw.sv
// Self-checking bench for seq_divider_dw: a DW=32 instance (directed table,
// hand-written corner sequences, random pairs) and a DW=8 instance (random
// pairs), both checked against plain arithmetic division.
module tb_seq_divider_dw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;

  logic        a_ivalid, a_oready, a_ovalid, a_iready, a_dz;
  logic [31:0] a_n, a_d, a_q, a_r;

  logic        b_ivalid, b_oready, b_ovalid, b_iready, b_dz;
  logic [7:0]  b_n, b_d, b_q, b_r;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider_dw #(.DW(32)) dut_a (
    .clk(clk), .resetn(resetn),
    .iValid(a_ivalid), .oReady(a_oready),
    .iDividend(a_n), .iDivisor(a_d),
    .oValid(a_ovalid), .iReady(a_iready),
    .oQuotient(a_q), .oRemainder(a_r), .oDivZero(a_dz)
  );

  seq_divider_dw #(.DW(8)) dut_b (
    .clk(clk), .resetn(resetn),
    .iValid(b_ivalid), .oReady(b_oready),
    .iDividend(b_n), .iDivisor(b_d),
    .oValid(b_ovalid), .iReady(b_iready),
    .oQuotient(b_q), .oRemainder(b_r), .oDivZero(b_dz)
  );

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          bp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 32-bit instance: wait for oReady, accept,
  // measure the edge at which oValid appears, check the result, hold it
  // for bp cycles with iReady low, then consume it.
  task automatic run32(input string name, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int bp, input bit rnd_ready);
    int k;
    bit held;
    k = 0;
    while (!a_oready && k < 100) begin tick(); k++; end
    check({name, " ready"}, a_oready, 1'b1);
    a_n = n; a_d = d; a_ivalid = 1'b1;
    tick();                                    // edge 0: accept
    a_ivalid = 1'b0; a_n = $urandom; a_d = $urandom;
    k = 0;
    while (!a_ovalid && k < 200) begin
      if (rnd_ready) a_iready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    a_iready = 1'b0;
    check({name, " valid"}, a_ovalid, 1'b1);
    check({name, " valid edge"}, k, (d == 0) ? 0 : 32);
    check({name, " quotient"}, a_q, eq);
    check({name, " remainder"}, a_r, er);
    check({name, " divzero"}, a_dz, edz);
    held = 1'b1;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (a_q !== eq || a_r !== er || a_dz !== edz || a_ovalid !== 1'b1 || a_oready !== 1'b0)
        held = 1'b0;
    end
    if (bp > 0) check({name, " held"}, held, 1'b1);
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    check({name, " consumed"}, {a_oready, a_ovalid}, 2'b10);
  endtask

  task automatic run8(input logic [7:0] n, input logic [7:0] d);
    int k;
    logic [7:0] eq, er;
    eq = (d == 0) ? 8'hFF : 8'(n / d);
    er = (d == 0) ? n : 8'(n % d);
    k = 0;
    while (!b_oready && k < 50) begin tick(); k++; end
    b_n = n; b_d = d; b_ivalid = 1'b1;
    tick();
    b_ivalid = 1'b0; b_n = 8'($urandom); b_d = 8'($urandom);
    k = 0;
    while (!b_ovalid && k < 50) begin
      b_iready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    b_iready = 1'b0;
    check("dw8 valid edge", k, (d == 0) ? 0 : 8);
    check("dw8 result", {b_q, b_r, b_dz}, {eq, er, (d == 0)});
    if ($urandom_range(0, 3) == 0) tick();
    b_iready = 1'b1;
    tick();
    b_iready = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   k;
    bit   quiet;

    vecs[0] = '{n: 32'd100,        d: 32'd7,          q: 32'd14,         r: 32'd2,    dz: 1'b0, bp: 0};
    vecs[1] = '{n: 32'hFFFF_FFFF,  d: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,    dz: 1'b0, bp: 0};
    vecs[2] = '{n: 32'd5,          d: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'd5,    dz: 1'b0, bp: 0};
    vecs[3] = '{n: 32'd1234,       d: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234, dz: 1'b1, bp: 2};
    vecs[4] = '{n: 32'd1000,       d: 32'd3,          q: 32'd333,        r: 32'd1,    dz: 1'b0, bp: 10};
    vecs[5] = '{n: 32'd0,          d: 32'd5,          q: 32'd0,          r: 32'd0,    dz: 1'b0, bp: 1};
    vecs[6] = '{n: 32'hFFFF_FFFF,  d: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,    dz: 1'b0, bp: 0};

    resetn   = 1'b0;
    a_ivalid = 1'b0; a_iready = 1'b0; a_n = '0; a_d = '0;
    b_ivalid = 1'b0; b_iready = 1'b0; b_n = '0; b_d = '0;
    #23;
    check("reset state", {a_oready, a_ovalid, a_dz}, 3'b100);
    check("reset outputs", {a_q, a_r}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("ready after reset", a_oready, 1'b1);

    // Directed table.
    for (int i = 0; i < 7; i++)
      run32($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r,
            vecs[i].dz, vecs[i].bp, 1'b0);

    // Backpressure with a second operand pending on iValid the whole time.
    a_n = 32'd1000; a_d = 32'd3; a_ivalid = 1'b1;
    tick();
    a_ivalid = 1'b0;
    k = 0;
    while (!a_ovalid && k < 200) begin a_iready = 1'b1; tick(); k++; end
    a_iready = 1'b0;
    check("bp first result", {a_q, a_r}, {32'd333, 32'd1});
    a_ivalid = 1'b1; a_n = 32'd2000; a_d = 32'd7;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_q !== 32'd333 || a_r !== 32'd1 || a_ovalid !== 1'b1 || a_oready !== 1'b0) quiet = 1'b0;
    end
    check("bp hold with iValid", quiet, 1'b1);
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    check("bp consumed", {a_oready, a_ovalid}, 2'b10);
    tick();
    a_ivalid = 1'b0;
    check("bp second accepted", a_oready, 1'b0);
    k = 0;
    while (!a_ovalid && k < 200) begin tick(); k++; end
    check("bp second edge", k, 32);
    check("bp second result", {a_q, a_r}, {32'd285, 32'd5});
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;

    // Abort by reset at BUSY step 10.
    a_n = 32'd50; a_d = 32'd5; a_ivalid = 1'b1;
    tick();
    a_ivalid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort busy", {a_oready, a_ovalid}, 2'b00);
    resetn = 1'b0;
    #1;
    check("abort outputs", {a_q, a_r, a_dz, a_ovalid}, 66'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("abort ready", a_oready, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_ovalid !== 1'b0) quiet = 1'b0;
    end
    check("abort no valid", quiet, 1'b1);
    run32("after abort", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0, 1'b0);

    // Random 32-bit pairs with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] n, d, eq, er;
      n = $urandom;
      case ($urandom_range(0, 9))
        0:       d = 32'd0;
        1, 2, 3: d = $urandom_range(1, 255);
        4, 5:    d = $urandom >> $urandom_range(0, 31);
        default: d = $urandom;
      endcase
      eq = (d == 0) ? 32'hFFFF_FFFF : n / d;
      er = (d == 0) ? n : n % d;
      run32($sformatf("rnd%0d %0h/%0h", i, n, d), n, d, eq, er, (d == 0),
            $urandom_range(0, 3), 1'b1);
    end

    // Random 8-bit pairs, including both all-zero and all-one corners.
    run8(8'hFF, 8'h01);
    run8(8'h00, 8'hFF);
    run8(8'h7B, 8'h00);
    for (int i = 0; i < 2000; i++) run8(8'($urandom), 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
